lsu: RTL
========

# lsu

Load/store unit sitting directly downstream of the ALU in the rvseed core. It takes the ALU result as the effective address, runs a single valid/ready transaction on the data bus, and returns a size-adjusted, sign- or zero-extended load result for register write-back. While a memory instruction is in flight it holds `stall` high, which the core uses to drive the `pc_reg` enable low so PC and register writes are frozen.

## Interface
- `DATA_WIDTH`, 32: data and address width; must equal `CPU_WIDTH`.
- `TIMEOUT`, 255: maximum number of BUS-state cycles spent waiting for `bus_ready`. 0 disables the timeout.

Ports:
- `clk` in 1: core clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `mem_req` in 1: current instruction is a load or store. Held stable by the core while `stall` = 1.
- `mem_we` in 1: 1 = store, 0 = load.
- `mem_size` in 3: funct3 of the instruction. 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU.
- `mem_addr` in 32: effective address (`alu_res`).
- `mem_wdata` in 32: store data (`reg2_rdata`).
- `stall` out 1: freeze the core.
- `mem_done` out 1: one-cycle pulse when the access completes.
- `mem_rdata` out 32: extended load data; valid while `mem_done` = 1.
- `mem_err` out 1: access failed (misaligned, illegal size, bus error or timeout); valid while `mem_done` = 1.
- `bus_valid` out 1: bus request.
- `bus_we` out 1: write.
- `bus_addr` out 32: word-aligned address, `{mem_addr[31:2], 2'b00}`.
- `bus_wdata` out 32: lane-replicated store data.
- `bus_be` out 4: byte enables.
- `bus_ready` in 1: bus accepts/completes the access this cycle. Read data and error are valid in the same cycle.
- `bus_rdata` in 32: read word.
- `bus_err` in 1: bus error, qualified by `bus_ready`.

## Operation
- FSM states: IDLE, BUS, DONE.
  - IDLE, `mem_req` = 0: stay in IDLE.
  - IDLE, `mem_req` = 1 and access is legal: latch address, size, we and wdata; go to BUS.
  - IDLE, `mem_req` = 1 and access is illegal: set error; go to DONE with no bus access.
  - BUS, `bus_ready` = 1: capture `bus_rdata`/`bus_err`; go to DONE.
  - BUS, timeout reached: set error; go to DONE.
  - DONE: always returns to IDLE.
- `stall` = `mem_req` & (state != DONE), combinational.
- Illegal accesses:
  - `mem_size` ∈ {011, 110, 111}.
  - A store with `mem_size[2]` = 1.
  - H/HU with `addr[0]` = 1.
  - W with `addr[1:0]` != 0.
- Store lanes:
  - SB: `bus_be` = 1 << `addr[1:0]`; `bus_wdata` = the low byte of `mem_wdata` replicated ×4.
  - SH: `bus_be` = 0011 or 1100 selected by `addr[1]`; `bus_wdata` = the low half replicated ×2.
  - SW: `bus_be` = 1111.
- Loads:
  - `bus_be` is computed exactly as for stores.
  - The byte/half lane is selected by `addr[1:0]`.
  - B/H sign-extend; BU/HU zero-extend.
- On any error, `mem_rdata` = 0 and `mem_err` = 1. The core must suppress the register write or trap; that behaviour is outside this block.
- Timeout counter:
  - Cleared on entry to BUS; increments on each BUS cycle without `bus_ready`.
  - When the count reaches `TIMEOUT`-1 with `bus_ready` still low: drop `bus_valid` and go to DONE with an error.
- `mem_req` dropping while in BUS is a protocol violation. The LSU ignores it and finishes the transaction.

## Timing
- Reset (asynchronous): state = IDLE; all counters cleared; all outputs 0 (`stall` follows `mem_req` combinationally). Reset asserted during BUS deasserts `bus_valid` immediately.
- `bus_valid`, `bus_we`, `bus_addr`, `bus_wdata` and `bus_be` are registered and held constant for the whole BUS state.
- Minimum latency, with `bus_ready` in the first BUS cycle:
  - Cycle 0: IDLE, `stall` = 1.
  - Cycle 1: BUS, `stall` = 1.
  - Cycle 2: DONE, `stall` = 0, `mem_done` = 1.
  - PC advances at the end of cycle 2, so a memory instruction takes 3 cycles plus one per bus wait cycle.
- Illegal access: 2 cycles (IDLE → DONE); `bus_valid` never asserts.
- Back-to-back memory instructions: the new instruction is sampled in the IDLE cycle that follows DONE. There is no overlap.
- `mem_done` and `mem_err` are registered and high for exactly one cycle.

## Test plan
- LW at 0x100, `bus_rdata` = 0xDEADBEEF, ready at first BUS cycle → `bus_be` = 1111, `bus_addr` = 0x100, `mem_rdata` = 0xDEADBEEF, `stall` high for 2 cycles, `mem_done` in cycle 2.
- LB/LBU at 0x103 with `bus_rdata` = 0x80FF_0000 → LB gives 0xFFFFFF80, LBU gives 0x00000080. LH at 0x102 gives 0xFFFF80FF.
- SB 0x12345678 at 0x101 → `bus_be` = 0010, `bus_wdata` = 0x78787878. SH at 0x102 → `bus_be` = 1100, `bus_wdata` = 0x56785678.
- LW at 0x102, and SW with `mem_size` = 100 → `bus_valid` never high, `mem_err` = 1, `mem_rdata` = 0, `mem_done` in cycle 1.
- `bus_ready` held low with `TIMEOUT` = 4 → `bus_valid` high 4 cycles, then drops; `mem_err` = 1. Separately, `bus_ready` = 1 with `bus_err` = 1 → `mem_err` = 1, `mem_rdata` = 0.
- `rst_n` pulsed low mid-BUS → `bus_valid`, `stall`-holding state and `mem_done` all clear asynchronously. After release, a new LW completes normally.

Source files
------------

// File: rtl/lsu_if.sv
// Data-bus side of the load/store unit: one valid/ready request with same-cycle
// read data and error.
interface lsu_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    valid;
    logic                    we;
    logic [DATA_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] be;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    err;

    modport master (
        output valid, we, addr, wdata, be,
        input  ready, rdata, err
    );

    modport slave (
        input  valid, we, addr, wdata, be,
        output ready, rdata, err
    );
endinterface

// File: rtl/lsu.sv
// Load/store unit: turns the ALU effective address into one data-bus transaction and
// returns a size-adjusted, extended load result while stalling the core.
module lsu #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [2:0]            mem_size,
    input  logic [DATA_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  stall,
    output logic                  mem_done,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_err,
    lsu_if.master                 bus
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StBus, StDone} state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  valid_q, valid_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]            be_q, be_d;
    logic [2:0]            size_q, size_d;
    logic [1:0]            addr_lo_q, addr_lo_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                  illegal;
    logic [3:0]            req_be;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  timeout_hit;

    // Request decode: legality and lane placement are taken straight from the core inputs.
    always_comb begin
        illegal = 1'b0;
        case (mem_size)
            3'b000, 3'b100: illegal = 1'b0;
            3'b001, 3'b101: illegal = mem_addr[0];
            3'b010:         illegal = (mem_addr[1:0] != 2'b00);
            default:        illegal = 1'b1;
        endcase
        if (mem_we && mem_size[2]) begin
            illegal = 1'b1;
        end

        req_be    = 4'b1111;
        req_wdata = mem_wdata;
        case (mem_size[1:0])
            2'b00: begin
                req_be    = 4'b0001 << mem_addr[1:0];
                req_wdata = {4{mem_wdata[7:0]}};
            end
            2'b01: begin
                req_be    = mem_addr[1] ? 4'b1100 : 4'b0011;
                req_wdata = {2{mem_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Load lane extraction uses the address and size latched at request time.
    always_comb begin
        ld_byte = 8'h00;
        unique case (addr_lo_q)
            2'd0: ld_byte = bus.rdata[7:0];
            2'd1: ld_byte = bus.rdata[15:8];
            2'd2: ld_byte = bus.rdata[23:16];
            2'd3: ld_byte = bus.rdata[31:24];
        endcase
        ld_half = addr_lo_q[1] ? bus.rdata[31:16] : bus.rdata[15:0];

        ld_data = bus.rdata;
        case (size_q)
            3'b000:  ld_data = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
            3'b001:  ld_data = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
            3'b101:  ld_data = {{(DATA_WIDTH-16){1'b0}}, ld_half};
            default: ld_data = bus.rdata;
        endcase
    end

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CntLast);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        size_d    = size_q;
        addr_lo_d = addr_lo_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        rdata_d   = '0;

        unique case (state_q)
            StIdle: begin
                if (mem_req) begin
                    if (illegal) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d   = StBus;
                        cnt_d     = '0;
                        valid_d   = 1'b1;
                        we_d      = mem_we;
                        addr_d    = {mem_addr[DATA_WIDTH-1:2], 2'b00};
                        wdata_d   = req_wdata;
                        be_d      = req_be;
                        size_d    = mem_size;
                        addr_lo_d = mem_addr[1:0];
                    end
                end
            end
            StBus: begin
                // A response in the last allowed cycle still wins over the timeout.
                if (bus.ready) begin
                    state_d = StDone;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    err_d   = bus.err;
                    rdata_d = (bus.err || we_q) ? '0 : ld_data;
                end else if (timeout_hit) begin
                    state_d = StDone;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            size_q    <= '0;
            addr_lo_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            size_q    <= size_d;
            addr_lo_q <= addr_lo_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

    assign stall     = mem_req & (state_q != StDone);
    assign mem_done  = done_q;
    assign mem_err   = err_q;
    assign mem_rdata = rdata_q;

    assign bus.valid = valid_q;
    assign bus.we    = we_q;
    assign bus.addr  = addr_q;
    assign bus.wdata = wdata_q;
    assign bus.be    = be_q;

endmodule
